// File: rtl/interrupt_block.sv
// Request/service core of an 8259-style interrupt controller: IRR latching,
// fixed-priority resolution, and ISR handling across INTA pulses and EOI.
module interrupt_block (
  input  logic       clk,
  input  logic       reset,
  input  logic       set,
  input  logic       i0,
  input  logic       i1,
  input  logic       i2,
  input  logic       i3,
  input  logic       i4,
  input  logic       i5,
  input  logic       i6,
  input  logic       i7,
  input  logic       level_or_edge_flag,
  input  logic [7:0] mask,
  input  logic       aeoi,
  input  logic       eoi,
  input  logic [1:0] intAcounter,
  output logic       INTtocontrol,
  output logic [2:0] ISRtocontrol
);

  // INTA protocol: control steps intAcounter 00 -> 01 (capture) -> 10 (release);
  // only a change into 01 or 10 acts, so a held count never retriggers.
  logic [7:0] irr;
  logic [7:0] isr;
  logic [7:0] in_prev;
  logic [1:0] inta_prev;
  logic       eoi_prev;
  logic [2:0] ack_idx;
  logic       ack_valid;

  logic [7:0] lines;
  logic [7:0] req;
  logic       req_found;
  logic [2:0] req_idx;
  logic       isr_found;
  logic [2:0] isr_idx;
  logic       cand_valid;
  logic       first_inta;
  logic       second_inta;
  logic       eoi_rise;
  logic [7:0] isr_next;
  logic [7:0] irr_next;
  logic [7:0] irr_clr;

  assign lines = {i7, i6, i5, i4, i3, i2, i1, i0};
  assign req   = irr & ~mask;

  // Scanning from 7 down to 0 leaves the lowest set index in each result.
  always_comb begin
    req_found = 1'b0;
    req_idx   = 3'd0;
    isr_found = 1'b0;
    isr_idx   = 3'd0;
    for (int n = 7; n >= 0; n--) begin
      if (req[n]) begin
        req_found = 1'b1;
        req_idx   = 3'(n);
      end
      if (isr[n]) begin
        isr_found = 1'b1;
        isr_idx   = 3'(n);
      end
    end
  end

  // Fully nested: only a request above every in-service level may interrupt.
  assign cand_valid   = req_found && (!isr_found || (req_idx < isr_idx));
  assign INTtocontrol = cand_valid;

  assign first_inta  = (intAcounter == 2'b01) && (inta_prev != 2'b01);
  assign second_inta = (intAcounter == 2'b10) && (inta_prev != 2'b10);
  assign eoi_rise    = eoi && !eoi_prev;

  always_comb begin
    isr_next = isr;
    irr_clr  = 8'h00;
    if (eoi_rise && isr_found) begin
      isr_next[isr_idx] = 1'b0;
    end
    if (second_inta && aeoi && ack_valid) begin
      isr_next[ack_idx] = 1'b0;
    end
    if (first_inta && cand_valid) begin
      isr_next[req_idx] = 1'b1;
      irr_clr[req_idx]  = 1'b1;
    end
    if (level_or_edge_flag) begin
      irr_next = lines & ~irr_clr;
    end else begin
      irr_next = (irr | (lines & ~in_prev)) & ~irr_clr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irr          <= 8'h00;
      isr          <= 8'h00;
      in_prev      <= 8'h00;
      inta_prev    <= 2'b00;
      eoi_prev     <= 1'b0;
      ack_idx      <= 3'd0;
      ack_valid    <= 1'b0;
      ISRtocontrol <= 3'd0;
    end else begin
      inta_prev <= intAcounter;
      eoi_prev  <= eoi;
      if (set) begin
        irr       <= 8'h00;
        isr       <= 8'h00;
        in_prev   <= 8'h00;
        ack_valid <= 1'b0;
      end else begin
        irr     <= irr_next;
        isr     <= isr_next;
        in_prev <= lines;
        if (first_inta) begin
          ISRtocontrol <= cand_valid ? req_idx : 3'b111;
          ack_idx      <= req_idx;
          ack_valid    <= cand_valid;
        end else if (second_inta) begin
          ack_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_interrupt_block.sv
// Bench for interrupt_block: directed walk through the main scenarios, then
// random traffic, all compared against an index-based reference model.
module tb_interrupt_block;

  logic       clk;
  logic       reset;
  logic       set;
  logic [7:0] lines;
  logic       level_or_edge_flag;
  logic [7:0] mask;
  logic       aeoi;
  logic       eoi;
  logic [1:0] inta;
  logic       int_out;
  logic [2:0] vec_out;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit [7:0] m_irr;
  bit [7:0] m_isr;
  bit [7:0] m_prev;
  bit [1:0] m_inta_prev;
  bit       m_eoi_prev;
  bit [2:0] m_vec;
  int       m_ack;

  interrupt_block dut (
    .clk                (clk),
    .reset              (reset),
    .set                (set),
    .i0                 (lines[0]),
    .i1                 (lines[1]),
    .i2                 (lines[2]),
    .i3                 (lines[3]),
    .i4                 (lines[4]),
    .i5                 (lines[5]),
    .i6                 (lines[6]),
    .i7                 (lines[7]),
    .level_or_edge_flag (level_or_edge_flag),
    .mask               (mask),
    .aeoi               (aeoi),
    .eoi                (eoi),
    .intAcounter        (inta),
    .INTtocontrol       (int_out),
    .ISRtocontrol       (vec_out)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lowest(input bit [7:0] v);
    for (int n = 0; n < 8; n++) begin
      if (v[n]) return n;
    end
    return 8;
  endfunction

  function automatic int model_cand();
    int c;
    int s;
    c = lowest(m_irr & ~mask);
    s = lowest(m_isr);
    return (c < 8 && c < s) ? c : -1;
  endfunction

  task automatic model_reset();
    m_irr       = 8'h00;
    m_isr       = 8'h00;
    m_prev      = 8'h00;
    m_inta_prev = 2'b00;
    m_eoi_prev  = 1'b0;
    m_vec       = 3'd0;
    m_ack       = -1;
  endtask

  // Advances the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit [7:0] n_irr;
    bit [7:0] n_isr;
    bit       first;
    bit       second;
    int       s;
    int       ack_now;
    if (set) begin
      m_irr  = 8'h00;
      m_isr  = 8'h00;
      m_prev = 8'h00;
      m_ack  = -1;
    end else begin
      first   = (inta == 2'd1) && (m_inta_prev != 2'd1);
      second  = (inta == 2'd2) && (m_inta_prev != 2'd2);
      s       = lowest(m_isr);
      ack_now = first ? model_cand() : -1;
      n_isr   = m_isr;
      if (eoi && !m_eoi_prev && s < 8) n_isr[s] = 1'b0;
      if (second && aeoi && m_ack >= 0) n_isr[m_ack] = 1'b0;
      if (ack_now >= 0) n_isr[ack_now] = 1'b1;
      for (int n = 0; n < 8; n++) begin
        if (level_or_edge_flag) n_irr[n] = lines[n];
        else n_irr[n] = m_irr[n] | (lines[n] & ~m_prev[n]);
        if (n == ack_now) n_irr[n] = 1'b0;
      end
      if (first) begin
        m_vec = (ack_now >= 0) ? 3'(ack_now) : 3'd7;
        m_ack = ack_now;
      end else if (second) begin
        m_ack = -1;
      end
      m_irr  = n_irr;
      m_isr  = n_isr;
      m_prev = lines;
    end
    m_inta_prev = inta;
    m_eoi_prev  = eoi;
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".int"}, 8'(int_out), 8'(model_cand() >= 0));
    check({tag, ".vec"}, 8'(vec_out), 8'(m_vec));
    check({tag, ".irr"}, dut.irr, m_irr);
    check({tag, ".isr"}, dut.isr, m_isr);
  endtask

  // driver: one clock with model update and full comparison
  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic pulse_set();
    set = 1'b1;
    tick("set");
    set = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set = 1'b0;
    lines = 8'h00;
    level_or_edge_flag = 1'b0;
    mask = 8'h00;
    aeoi = 1'b1;
    eoi = 1'b0;
    inta = 2'b00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_int", 8'(int_out), 8'h00);
    check("rst_vec", 8'(vec_out), 8'h00);
    check("rst_irr", dut.irr, 8'h00);
    check("rst_isr", dut.isr, 8'h00);

    // edge mode, AEOI, three staggered requests
    lines = 8'h02; tick("e1");
    lines = 8'h03; tick("e0");
    lines = 8'h83; tick("e7");
    check("t1_irr", dut.irr, 8'h83);
    check("t1_int", 8'(int_out), 8'h01);
    inta = 2'd1; tick("t1_ack1");
    check("t1_vec", 8'(vec_out), 8'h00);
    check("t1_isr", dut.isr, 8'h01);
    check("t1_irr2", dut.irr, 8'h82);
    inta = 2'd2; tick("t1_ack2");
    check("t1_aeoi", dut.isr, 8'h00);
    check("t1_int2", 8'(int_out), 8'h01);
    inta = 2'd0; tick("t1_idle");

    // masking
    lines = 8'h00; pulse_set();
    lines = 8'h03; tick("m_req");
    mask = 8'h03; tick("m_mask3");
    check("m_int0", 8'(int_out), 8'h00);
    mask = 8'h01; tick("m_mask1");
    check("m_int1", 8'(int_out), 8'h01);
    inta = 2'd1; tick("m_ack1");
    check("m_vec", 8'(vec_out), 8'h01);
    inta = 2'd2; tick("m_ack2");
    inta = 2'd0; mask = 8'h00; tick("m_idle");

    // fully nested, no AEOI
    aeoi = 1'b0; lines = 8'h00; pulse_set();
    lines = 8'h08; tick("n_i3");
    inta = 2'd1; tick("n_ack3");
    check("n_isr08", dut.isr, 8'h08);
    inta = 2'd0; tick("n_idle");
    lines = 8'h28; tick("n_i5");
    check("n_blocked", 8'(int_out), 8'h00);
    lines = 8'h2C; tick("n_i2");
    check("n_preempt", 8'(int_out), 8'h01);
    inta = 2'd1; tick("n_ack2");
    check("n_isr0c", dut.isr, 8'h0C);
    inta = 2'd0; tick("n_idle2");
    eoi = 1'b1; tick("n_eoi1");
    check("n_eoi_b2", dut.isr, 8'h08);
    eoi = 1'b0; tick("n_eoi1_low");
    eoi = 1'b1; tick("n_eoi2");
    check("n_eoi_b3", dut.isr, 8'h00);
    check("n_i5_reint", 8'(int_out), 8'h01);
    eoi = 1'b0; tick("n_eoi2_low");

    // level mode with a request that goes away
    lines = 8'h00; level_or_edge_flag = 1'b1; pulse_set();
    lines = 8'h10; tick("l_hi");
    check("l_irr4", 8'(dut.irr[4]), 8'h01);
    lines = 8'h00; tick("l_lo");
    check("l_irr4_lo", 8'(dut.irr[4]), 8'h00);
    check("l_int0", 8'(int_out), 8'h00);
    inta = 2'd1; tick("l_spur");
    check("l_vec7", 8'(vec_out), 8'h07);
    check("l_isr", dut.isr, 8'h00);
    inta = 2'd0; tick("l_idle");

    // edge mode: held line does not re-request
    level_or_edge_flag = 1'b0; pulse_set();
    lines = 8'h40; tick("h_i6");
    inta = 2'd1; tick("h_ack");
    inta = 2'd0; tick("h_idle");
    eoi = 1'b1; tick("h_eoi");
    eoi = 1'b0; tick("h_eoi_low");
    check("h_noreq", 8'(dut.irr[6]), 8'h00);
    check("h_int0", 8'(int_out), 8'h00);
    lines = 8'h00; tick("h_drop");
    lines = 8'h40; tick("h_rise");
    check("h_irr6", 8'(dut.irr[6]), 8'h01);

    // asynchronous reset mid-sequence, then synchronous set
    lines = 8'h00; pulse_set();
    lines = 8'h01; tick("r_i0");
    inta = 2'd1; tick("r_ack");
    check("r_isr01", dut.isr, 8'h01);
    #2;
    reset = 1'b1;
    inta = 2'd0;
    #1;
    check("r_int", 8'(int_out), 8'h00);
    check("r_vec", 8'(vec_out), 8'h00);
    check("r_irr", dut.irr, 8'h00);
    check("r_isr", dut.isr, 8'h00);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick("r_after");
    lines = 8'h00; tick("r_lo");
    lines = 8'hFF; tick("r_ff");
    check("s_irrff", dut.irr, 8'hFF);
    set = 1'b1; tick("s_set");
    check("s_irr0", dut.irr, 8'h00);
    set = 1'b0;

    // random traffic
    for (int blk = 0; blk < 6; blk++) begin
      level_or_edge_flag = blk[0];
      aeoi = blk[1];
      for (int c = 0; c < 80; c++) begin
        lines = lines ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
        if ($urandom_range(0, 15) == 0) mask = 8'($urandom) & 8'($urandom);
        if ($urandom_range(0, 2) == 0) inta = 2'($urandom_range(0, 3));
        eoi = ($urandom_range(0, 5) == 0);
        set = ($urandom_range(0, 60) == 0);
        tick("rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
